// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the adder result accumulator slice.
//   - acc_state_t : block state, either collecting results or holding a total
//   - RES_W       : width of one adder result {C32, S[32:1]}
// ---------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [0:0] {
        ACCUM,
        DRAIN
    } acc_state_t;

    localparam int RES_W = 33;

endpackage

// File: rtl/adder_result_acc_add_stage.sv
// ---------------------------------------------------------------------------
// acc_add_stage
//   Purely combinational ACC_W-bit adder. It adds the running accumulator to
//   one zero-extended 33-bit adder result. It returns the wrapped sum and the
//   carry out of bit ACC_W-1.
// Ports
//   acc_i   in   ACC_W   current accumulator value
//   res_i   in   RES_W   adder result {C32, S}
//   sum_o   out  ACC_W   (acc_i + res_i) modulo 2^ACC_W
//   carry_o out  1       carry out of the ACC_W-bit add
// ---------------------------------------------------------------------------
module acc_add_stage
    import adder_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [RES_W-1:0] res_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    // One extra bit on the left catches the carry out of the accumulator width
    logic [ACC_W:0] wideSum;

    assign wideSum          = {1'b0, acc_i} + {{(ACC_W + 1 - RES_W){1'b0}}, res_i};
    assign {carry_o, sum_o} = wideSum;

endmodule

// File: rtl/adder_result_acc.sv
// ---------------------------------------------------------------------------
// adder_result_acc
//   Collects 33-bit adder results over a valid/ready handshake and sums them
//   into an ACC_W-bit accumulator. A block closes on in_last or on the
//   MAX_CNT-th result. The block total, the result count and a sticky
//   overflow flag are then held on a registered output until they are taken.
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        adder result present
//   in_ready   out  1        a result is accepted this cycle
//   in_sum     in   32       adder sum S[32:1]
//   in_c32     in   1        adder carry-out C32
//   in_last    in   1        this result closes the block
//   out_valid  out  1        block total available
//   out_ready  in   1        downstream takes the total
//   out_acc    out  ACC_W    block total modulo 2^ACC_W
//   out_count  out  CNT_W    number of results in the block
//   out_ovf    out  1        sticky carry out of the accumulator
// ---------------------------------------------------------------------------
module adder_result_acc
    import adder_pkg::*;
#(
    parameter int ACC_W   = 48,
    parameter int MAX_CNT = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [31:0]                      in_sum,
    input  logic                             in_c32,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_W-1:0]                 out_acc,
    output logic [$clog2(MAX_CNT + 1)-1:0]   out_count,
    output logic                             out_ovf
);

    localparam int CNT_W = $clog2(MAX_CNT + 1);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] outAcc_q, outAcc_d;
    logic [CNT_W-1:0] outCount_q, outCount_d;
    logic             outOvf_q, outOvf_d;
    logic             outValid_q, outValid_d;

    logic [ACC_W-1:0] addSum;
    logic             addCarry;

    acc_add_stage #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i   (acc_q),
        .res_i   ({in_c32, in_sum}),
        .sum_o   (addSum),
        .carry_o (addCarry)
    );

    // Next-state logic. In ACCUM every handshake folds one result into the
    // accumulator; the closing handshake also snapshots the updated values
    // into the output registers so the total is visible one cycle later.
    // In DRAIN the input side is closed, and taking the output clears the
    // accumulator so the next block starts from zero. A close on in_last and
    // on the count limit at the same time is still a single close.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        outAcc_d   = outAcc_q;
        outCount_d = outCount_q;
        outOvf_d   = outOvf_q;
        outValid_d = outValid_q;
        in_ready   = 1'b0;

        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = addSum;
                    count_d = count_q + CNT_W'(1);
                    ovf_d   = ovf_q | addCarry;
                    if (in_last || (count_q == CNT_W'(MAX_CNT - 1))) begin
                        outAcc_d   = acc_d;
                        outCount_d = count_d;
                        outOvf_d   = ovf_d;
                        outValid_d = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (outValid_q && out_ready) begin
                    outValid_d = 1'b0;
                    acc_d      = '0;
                    count_d    = '0;
                    ovf_d      = 1'b0;
                    state_d    = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State and data registers; reset drops any partial block
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            outAcc_q   <= '0;
            outCount_q <= '0;
            outOvf_q   <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            outAcc_q   <= outAcc_d;
            outCount_q <= outCount_d;
            outOvf_q   <= outOvf_d;
            outValid_q <= outValid_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_acc   = outAcc_q;
    assign out_count = outCount_q;
    assign out_ovf   = outOvf_q;

endmodule

// File: tb/tb_adder_result_acc.sv
// ---------------------------------------------------------------------------
// tb_adder_result_acc
//   Drives two accumulators (ACC_W=48 and ACC_W=34, both MAX_CNT=16) through
//   shared stimulus; sel34 picks which one is active. Block totals predicted
//   by the bench are queued when the inputs are sent and popped when the
//   DUT presents out_valid.
// ---------------------------------------------------------------------------
module tb_adder_result_acc;

    typedef struct packed {
        logic [47:0] acc;
        logic [4:0]  cnt;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    = 1'b1;
    logic        vld    = 1'b0;
    logic        inC32  = 1'b0;
    logic        inLast = 1'b0;
    logic        outRdy = 1'b0;
    logic        sel34  = 1'b0;
    logic [31:0] inSum  = '0;

    logic        rdy48, ov48, of48;
    logic [47:0] oa48;
    logic [4:0]  oc48;
    logic        rdy34, ov34, of34;
    logic [33:0] oa34;
    logic [4:0]  oc34;

    logic inValid48, inValid34, outReady48, outReady34;
    assign inValid48  = vld & ~sel34;
    assign inValid34  = vld & sel34;
    assign outReady48 = outRdy & ~sel34;
    assign outReady34 = outRdy & sel34;

    adder_result_acc #(.ACC_W(48), .MAX_CNT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid48), .in_ready(rdy48),
        .in_sum(inSum), .in_c32(inC32), .in_last(inLast),
        .out_valid(ov48), .out_ready(outReady48),
        .out_acc(oa48), .out_count(oc48), .out_ovf(of48)
    );

    adder_result_acc #(.ACC_W(34), .MAX_CNT(16)) dut34 (
        .clk(clk), .rst(rst), .in_valid(inValid34), .in_ready(rdy34),
        .in_sum(inSum), .in_c32(inC32), .in_last(inLast),
        .out_valid(ov34), .out_ready(outReady34),
        .out_acc(oa34), .out_count(oc34), .out_ovf(of34)
    );

    // Observed view of whichever DUT is currently selected
    logic        obsReady, obsValid, obsOvf;
    logic [47:0] obsAcc;
    logic [4:0]  obsCount;
    always_comb begin
        if (sel34) begin
            obsReady = rdy34; obsValid = ov34; obsOvf = of34;
            obsAcc   = {14'd0, oa34}; obsCount = oc34;
        end else begin
            obsReady = rdy48; obsValid = ov48; obsOvf = of48;
            obsAcc   = oa48; obsCount = oc48;
        end
    end

    int compared   = 0;
    int mismatched = 0;

    // Reference model and scoreboard
    logic [63:0] mAcc;
    int          mCount;
    logic        mOvf;
    exp_t        sb[$];

    task automatic modelClear();
        mAcc = '0; mCount = 0; mOvf = 1'b0;
    endtask

    task automatic modelAdd(input logic c, input logic [31:0] s, input logic last);
        int          accW;
        logic [63:0] mask;
        exp_t        e;
        accW = sel34 ? 34 : 48;
        mask = (64'd1 << accW) - 64'd1;
        mAcc = mAcc + {31'd0, c, s};
        if ((mAcc & ~mask) != 64'd0) mOvf = 1'b1;
        mAcc = mAcc & mask;
        mCount++;
        if (last || mCount == 16) begin
            e.acc = mAcc[47:0]; e.cnt = mCount[4:0]; e.ovf = mOvf;
            sb.push_back(e);
            modelClear();
        end
    endtask

    // One input handshake on the selected DUT, bounded wait for in_ready
    task automatic applyStimulus(input logic c, input logic [31:0] s, input logic last);
        int guard = 0;
        @(negedge clk);
        while (obsReady !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (obsReady !== 1'b1) begin
            compared++; mismatched++;
            $display("[TB] FAIL send_ready: in_ready=%b required 1 (timeout)", obsReady);
        end else begin
            vld = 1'b1; inC32 = c; inSum = s; inLast = last;
            @(posedge clk); #1;
            vld = 1'b0; inLast = 1'b0;
            modelAdd(c, s, last);
        end
    endtask

    // Wait for out_valid; waited=0 means visible at the first falling edge
    task automatic waitOut(output int waited);
        waited = 0;
        @(negedge clk);
        while (obsValid !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (obsValid !== 1'b1) waited = -1;
    endtask

    task automatic takeOut();
        @(negedge clk); outRdy = 1'b1;
        @(posedge clk); #1; outRdy = 1'b0;
    endtask

    task automatic test_reset();
        int   w;
        exp_t e;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compared++;
        if (obsValid !== 1'b0 || obsAcc !== 48'd0 || obsCount !== 5'd0 || obsOvf !== 1'b0 || obsReady !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_state: valid=%b acc=%h cnt=%0d ovf=%b ready=%b required 0/0/0/0/1", obsValid, obsAcc, obsCount, obsOvf, obsReady);
        end
        applyStimulus(1'b0, 32'h30, 1'b1);
        waitOut(w);
        compared++;
        if (w < 0 || sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL reset_pre_block: waited=%0d pending=%0d required a total", w, sb.size());
        end else begin
            e = sb.pop_front();
            compared++;
            if (obsAcc !== e.acc) begin
                mismatched++;
                $display("[TB] FAIL reset_pre_acc: got %h required %h", obsAcc, e.acc);
            end
        end
        takeOut();
        applyStimulus(1'b0, 32'h11, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        modelClear();
        compared++;
        if (obsValid !== 1'b0 || obsAcc !== 48'd0 || obsCount !== 5'd0 || obsOvf !== 1'b0 || obsReady !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_block: valid=%b acc=%h cnt=%0d ovf=%b ready=%b required 0/0/0/0/1", obsValid, obsAcc, obsCount, obsOvf, obsReady);
        end
        @(negedge clk);
        compared++;
        if (obsReady !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_ready_next: got %b required 1", obsReady);
        end
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 32'(i * 3), i == 5);
        waitOut(w);
        compared++;
        if (w < 0 || sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL reset_post_block: waited=%0d pending=%0d required a total", w, sb.size());
        end else begin
            e = sb.pop_front();
            compared++;
            if (obsAcc !== e.acc || obsCount !== e.cnt || obsAcc !== 48'd45) begin
                mismatched++;
                $display("[TB] FAIL reset_post_total: acc=%h cnt=%0d required %h/%0d", obsAcc, obsCount, e.acc, e.cnt);
            end
        end
        takeOut();
    endtask

    task automatic test_basic();
        int   w;
        exp_t e;
        applyStimulus(1'b0, 32'h1, 1'b0);
        applyStimulus(1'b0, 32'h2, 1'b0);
        applyStimulus(1'b1, 32'h0, 1'b1);
        waitOut(w);
        compared++;
        if (w != 0 || sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL basic_latency: waited=%0d pending=%0d required 0 and 1", w, sb.size());
        end else begin
            e = sb.pop_front();
            compared++;
            if (obsAcc !== e.acc || obsAcc !== 48'h1_0000_0003) begin
                mismatched++;
                $display("[TB] FAIL basic_acc: got %h required %h", obsAcc, e.acc);
            end
            compared++;
            if (obsCount !== e.cnt || obsOvf !== e.ovf) begin
                mismatched++;
                $display("[TB] FAIL basic_cnt_ovf: got %0d/%b required %0d/%b", obsCount, obsOvf, e.cnt, e.ovf);
            end
        end
        takeOut();
    endtask

    task automatic test_max_count();
        int   w;
        exp_t e;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
        waitOut(w);
        compared++;
        if (w != 0 || sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL max_close: waited=%0d pending=%0d required 0 and 1", w, sb.size());
        end else begin
            e = sb.pop_front();
            compared++;
            if (obsAcc !== e.acc || obsAcc !== 48'h1F_FFFF_FFF0) begin
                mismatched++;
                $display("[TB] FAIL max_acc: got %h required %h", obsAcc, e.acc);
            end
            compared++;
            if (obsCount !== 5'd16 || obsReady !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL max_cnt_ready: cnt=%0d ready=%b required 16/0", obsCount, obsReady);
            end
        end
        takeOut();
    endtask

    task automatic test_wrap34();
        int   w;
        exp_t e;
        @(negedge clk); sel34 = 1'b1;
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 32'hFFFF_FFFF, i == 3);
        waitOut(w);
        compared++;
        if (w < 0 || sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL wrap_close: waited=%0d pending=%0d required a total", w, sb.size());
        end else begin
            e = sb.pop_front();
            compared++;
            if (obsAcc !== e.acc || obsAcc !== 48'h1_FFFF_FFFD) begin
                mismatched++;
                $display("[TB] FAIL wrap_acc: got %h required %h", obsAcc, e.acc);
            end
            compared++;
            if (obsOvf !== 1'b1 || obsCount !== e.cnt) begin
                mismatched++;
                $display("[TB] FAIL wrap_ovf: ovf=%b cnt=%0d required 1/%0d", obsOvf, obsCount, e.cnt);
            end
        end
        takeOut();
    endtask

    task automatic test_single();
        int   w;
        exp_t e;
        // Runs once on each DUT; the ACC_W=34 one carries a set ovf from before
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(1'b0, 32'h0000_000A, 1'b1);
            waitOut(w);
            compared++;
            if (w < 0 || sb.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL single_close%0d: waited=%0d pending=%0d required a total", pass, w, sb.size());
            end else begin
                e = sb.pop_front();
                compared++;
                if (obsAcc !== 48'hA || obsCount !== 5'd1 || obsOvf !== 1'b0 || obsAcc !== e.acc) begin
                    mismatched++;
                    $display("[TB] FAIL single_total%0d: acc=%h cnt=%0d ovf=%b required a/1/0", pass, obsAcc, obsCount, obsOvf);
                end
            end
            takeOut();
            @(negedge clk); sel34 = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int   w;
        exp_t e;
        applyStimulus(1'b0, 32'h10, 1'b0);
        applyStimulus(1'b0, 32'h20, 1'b1);
        waitOut(w);
        if (w < 0 || sb.size() == 0) begin
            compared++; mismatched++;
            $display("[TB] FAIL bp_close: waited=%0d pending=%0d required a total", w, sb.size());
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                vld = (i % 2 == 0); inLast = 1'b1; inSum = 32'h77;
                compared++;
                if (obsValid !== 1'b1 || obsAcc !== e.acc || obsCount !== e.cnt || obsReady !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL bp_hold%0d: valid=%b acc=%h cnt=%0d ready=%b required 1/%h/%0d/0", i, obsValid, obsAcc, obsCount, obsReady, e.acc, e.cnt);
                end
            end
            @(negedge clk); vld = 1'b1; outRdy = 1'b1;
            @(posedge clk); #1; outRdy = 1'b0; vld = 1'b0; inLast = 1'b0;
            @(negedge clk);
            compared++;
            if (obsValid !== 1'b0 || obsReady !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL bp_release: valid=%b ready=%b required 0/1", obsValid, obsReady);
            end
        end
        applyStimulus(1'b0, 32'h5, 1'b1);
        waitOut(w);
        compared++;
        if (w < 0 || sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL bp_next_close: waited=%0d pending=%0d required a total", w, sb.size());
        end else begin
            e = sb.pop_front();
            compared++;
            if (obsAcc !== e.acc || obsCount !== e.cnt) begin
                mismatched++;
                $display("[TB] FAIL bp_next_total: acc=%h cnt=%0d required %h/%0d", obsAcc, obsCount, e.acc, e.cnt);
            end
        end
        takeOut();
    endtask

    initial begin
        modelClear();
        test_reset();
        test_basic();
        test_max_count();
        test_wrap34();
        test_single();
        test_back_to_back();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL sb_leftover: %0d totals never seen, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
